gpio_arb: RTL

//  Two-port round-robin arbiter sharing the single gpio register port (mode/data regs,

---
 rtl/gpio_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gpio_arb.sv
// Round-robin arbiter sharing the gpio register port between CPU bus (port 0) and bit-bang engine (port 1).
// Grant edge -> wr_en visible next cycle -> ack the cycle after; requests stay pending until granted.
module gpio_arb #(
    parameter int AW       = 3,
    parameter int DW       = 32,
    parameter int BW       = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    input  logic [1:0]    i_req,
    input  logic [1:0]    i_lock,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_din0,
    input  logic [DW-1:0] i_din1,
    input  logic [BW-1:0] i_wr_en0,
    input  logic [BW-1:0] i_wr_en1,
    output logic [1:0]    o_ack,
    output logic [DW-1:0] o_rdata,
    output logic [1:0]    o_gnt,
    output logic [AW-1:0] o_gpio_addr,
    output logic [DW-1:0] o_gpio_din,
    output logic [BW-1:0] o_gpio_wr_en,
    input  logic [DW-1:0] i_gpio_dout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam int         CW       = $clog2(LOCK_MAX + 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic          lock_act_q, lock_act_d;
    logic          lock_own_q, lock_own_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [BW-1:0] wr_en_q, wr_en_d;
    logic          arb;
    logic          sel;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        ack_d      = 2'b00;
        gnt_d      = gnt_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        din_d      = din_q;
        wr_en_d    = '0;
        arb        = 1'b0;
        sel        = 1'b0;

        case (state_q)
            ST_IDLE: arb = 1'b1;
            ST_ISSUE: begin
                rdata_d = i_gpio_dout;
                ack_d   = gnt_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                rr_d = ~owner_q;
                if (i_lock[owner_q] && ((int'(lock_cnt_q) + 1) < LOCK_MAX)) begin
                    lock_act_d = 1'b1;
                    lock_own_d = owner_q;
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end else begin
                    lock_act_d = 1'b0;
                    lock_cnt_d = '0;
                end
                // Re-arbitrate on the same edge so back-to-back accesses cost two cycles each.
                arb = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb) begin
            if (lock_act_d && i_req[lock_own_d]) begin
                sel = lock_own_d;
            end else if (i_req == 2'b10) begin
                sel = 1'b1;
            end else if (i_req == 2'b01) begin
                sel = 1'b0;
            end else begin
                sel = rr_d;
            end

            if (|i_req) begin
                state_d = ST_ISSUE;
                owner_d = sel;
                gnt_d   = sel ? 2'b10 : 2'b01;
                addr_d  = sel ? i_addr1  : i_addr0;
                din_d   = sel ? i_din1   : i_din0;
                wr_en_d = sel ? i_wr_en1 : i_wr_en0;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
            lock_act_q <= 1'b0;
            lock_own_q <= 1'b0;
            lock_cnt_q <= '0;
            ack_q      <= 2'b00;
            gnt_q      <= 2'b00;
            rdata_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            wr_en_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            ack_q      <= ack_d;
            gnt_q      <= gnt_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign o_ack        = ack_q;
    assign o_gnt        = gnt_q;
    assign o_rdata      = rdata_q;
    assign o_gpio_addr  = addr_q;
    assign o_gpio_din   = din_q;
    assign o_gpio_wr_en = wr_en_q;

endmodule
